// File: rtl/packetizer.sv
// Buffers one packet of 16-bit words, then emits a 48-bit header flit and one body flit per word.
// Optional build macro PACKETIZER_CRC_EN places an XOR checksum of the words in the header chk field.
module packetizer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic        data_last,
  input  logic [15:0] dest,
  output logic        data_ready,
  output logic [47:0] flitout,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic        pkt_sent
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [15:0] dest_q, dest_d;
  logic [47:0] flitout_q, flitout_d;
  logic        flit_valid_q, flit_valid_d;
  logic        pkt_sent_q, pkt_sent_d;
  logic [15:0] chk_s;
  logic        word_acc_s, flit_acc_s, last_rd_s;
  logic [15:0] mem_q [DEPTH];
`ifdef PACKETIZER_CRC_EN
  logic [15:0] crc_q, crc_d;
`endif

  assign data_ready = (state_q == FILL);
  assign word_acc_s = data_ready & data_valid;
  assign flit_acc_s = flit_valid_q & flit_ready;
  assign last_rd_s  = ({1'b0, rd_q} == (cnt_q - (AW+1)'(1)));

  assign flitout    = flitout_q;
  assign flit_valid = flit_valid_q;
  assign pkt_sent   = pkt_sent_q;

  // Next-state, buffer bookkeeping and the next flit to present
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    dest_d       = dest_q;
    flitout_d    = flitout_q;
    flit_valid_d = flit_valid_q;
    pkt_sent_d   = 1'b0;
    chk_s        = 16'h0000;
`ifdef PACKETIZER_CRC_EN
    crc_d        = crc_q;
`endif
    case (state_q)
      FILL: begin
        if (word_acc_s) begin
          cnt_d  = cnt_q + (AW+1)'(1);
          dest_d = (cnt_q == {(AW+1){1'b0}}) ? dest : dest_q;
`ifdef PACKETIZER_CRC_EN
          crc_d  = crc_q ^ data_in;
          chk_s  = crc_d;
`endif
          // A full buffer closes the packet even without data_last
          if (data_last || (cnt_d == (AW+1)'(DEPTH))) begin
            state_d      = HEAD;
            flit_valid_d = 1'b1;
            flitout_d    = {dest_d, 16'(cnt_d), chk_s};
          end else begin
            state_d = FILL;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      HEAD: begin
        if (flit_acc_s) begin
          state_d   = BODY;
          rd_d      = {AW{1'b0}};
          flitout_d = {16'h0000, mem_q[0],
                       (cnt_q == (AW+1)'(1)) ? 16'hFFFF : 16'h0000};
        end else begin
          state_d = HEAD;
        end
      end
      BODY: begin
        if (flit_acc_s) begin
          if (last_rd_s) begin
            state_d      = FILL;
            cnt_d        = {(AW+1){1'b0}};
            rd_d         = {AW{1'b0}};
            flit_valid_d = 1'b0;
            flitout_d    = 48'h0;
            pkt_sent_d   = 1'b1;
`ifdef PACKETIZER_CRC_EN
            crc_d        = 16'h0000;
`endif
          end else begin
            rd_d      = rd_q + AW'(1);
            flitout_d = {16'(rd_d), mem_q[rd_d],
                         ({1'b0, rd_d} == (cnt_q - (AW+1)'(1))) ? 16'hFFFF : 16'h0000};
          end
        end else begin
          state_d = BODY;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      cnt_q        <= {(AW+1){1'b0}};
      rd_q         <= {AW{1'b0}};
      dest_q       <= 16'h0000;
      flitout_q    <= 48'h0;
      flit_valid_q <= 1'b0;
      pkt_sent_q   <= 1'b0;
`ifdef PACKETIZER_CRC_EN
      crc_q        <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      dest_q       <= dest_d;
      flitout_q    <= flitout_d;
      flit_valid_q <= flit_valid_d;
      pkt_sent_q   <= pkt_sent_d;
`ifdef PACKETIZER_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  // Word buffer; contents are don't-care until written in FILL
  always_ff @(posedge clk) begin
    if (word_acc_s) begin
      mem_q[cnt_q[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_packetizer.sv
// Directed bench for packetizer: a packet-level model predicts every flit, the
// handshake outputs and pkt_sent; literal expectations pin the model.
module tb_packetizer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_last;
  logic [15:0] dest;
  logic        data_ready;
  logic [47:0] flitout;
  logic        flit_valid;
  logic        flit_ready;
  logic        pkt_sent;

  packetizer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .dest(dest), .data_ready(data_ready),
    .flitout(flitout), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];
  logic [15:0] pkt_w[$];
  bit          exp_pulse = 1'b0;
  bit          hold_valid = 1'b0;
  logic [47:0] hold_val = 48'h0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every falling edge checks the DUT against the model
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_data_ready", {47'h0, data_ready}, 48'h1);
      check("rst_flit_valid", {47'h0, flit_valid}, 48'h0);
      check("rst_pkt_sent", {47'h0, pkt_sent}, 48'h0);
      check("rst_flitout", flitout, 48'h0);
      exp_pulse  = 1'b0;
      hold_valid = 1'b0;
    end else begin
      check("data_ready", {47'h0, data_ready}, {47'h0, exp_q.size() == 0});
      check("flit_valid", {47'h0, flit_valid}, {47'h0, exp_q.size() != 0});
      check("pkt_sent", {47'h0, pkt_sent}, {47'h0, exp_pulse});
      if (hold_valid) check("flit_hold", flitout, hold_val);
      hold_valid = flit_valid && !flit_ready;
      hold_val   = flitout;
      if (flit_valid && flit_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_flit", flitout, 48'h0);
          exp_pulse = 1'b0;
        end else begin
          check("flit", flitout, exp_q[0]);
          void'(exp_q.pop_front());
          got_q.push_back(flitout);
          exp_pulse = (exp_q.size() == 0);
        end
      end else begin
        exp_pulse = 1'b0;
      end
    end
  end

  // Sends pkt_w; returns once the closing word is accepted and queues the expected flits
  task automatic send_pkt(input logic [15:0] d, input bit use_last);
    int n = 0;
    logic [15:0] acc = 16'h0000;
    logic [15:0] chk;
    for (int i = 0; i < pkt_w.size(); i++) begin
      int k = 0;
      while (!data_ready && k < 200) begin
        tick();
        k++;
      end
      if (!data_ready) begin
        check("send_timeout", 48'h0, 48'h1);
        break;
      end
      data_valid = 1'b1;
      data_in    = pkt_w[i];
      dest       = (i == 0) ? d : ~d;
      data_last  = use_last && (i == pkt_w.size() - 1);
      tick();
      n++;
      acc = acc ^ pkt_w[i];
      if (data_last || n == DEPTH) break;
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    data_in    = 16'h0000;
`ifdef PACKETIZER_CRC_EN
    chk = acc;
`else
    chk = 16'h0000;
`endif
    exp_q.push_back({d, 16'(n), chk});
    for (int i = 0; i < n; i++)
      exp_q.push_back({16'(i), pkt_w[i], (i == n - 1) ? 16'hFFFF : 16'h0000});
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 48'(exp_q.size()), 48'h0);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    data_in = 16'h0; data_valid = 1'b0; data_last = 1'b0; dest = 16'h0;
    flit_ready = 1'b1; reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("idle_flitout", flitout, 48'h0);
    check("idle_ready", {47'h0, data_ready}, 48'h1);
    tick();

    // Single word
    got_q.delete();
    pkt_w = '{16'hABCD};
    send_pkt(16'h1234, 1'b1);
    drain();
    check("t1_count", 48'(got_q.size()), 48'd2);
`ifdef PACKETIZER_CRC_EN
    check("t1_hdr", got_q[0], 48'h1234_0001_ABCD);
`else
    check("t1_hdr", got_q[0], 48'h1234_0001_0000);
`endif
    check("t1_body", got_q[1], 48'h0000_ABCD_FFFF);

    // Three words
    got_q.delete();
    pkt_w = '{16'h3232, 16'h6767, 16'h0001};
    send_pkt(16'h0002, 1'b1);
    drain();
    check("t2_count", 48'(got_q.size()), 48'd4);
`ifdef PACKETIZER_CRC_EN
    check("t2_hdr", got_q[0], 48'h0002_0003_5554);
`else
    check("t2_hdr", got_q[0], 48'h0002_0003_0000);
`endif
    check("t2_b0", got_q[1], 48'h0000_3232_0000);
    check("t2_b1", got_q[2], 48'h0001_6767_0000);
    check("t2_b2", got_q[3], 48'h0002_0001_FFFF);

    // Backpressure in BODY with stray data_valid
    got_q.delete();
    pkt_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    send_pkt(16'h0BB0, 1'b1);
    repeat (2) tick();
    flit_ready = 1'b0;
    data_valid = 1'b1; data_in = 16'hDEAD; data_last = 1'b1;
    repeat (5) tick();
    check("t3_ready_low", {47'h0, data_ready}, 48'h0);
    data_valid = 1'b0; data_in = 16'h0; data_last = 1'b0;
    flit_ready = 1'b1;
    drain();
    check("t3_count", 48'(got_q.size()), 48'd5);
    check("t3_b1", got_q[2], 48'h0001_2222_0000);
    check("t3_b3", got_q[4], 48'h0003_4444_FFFF);

    // Overflow: 16 words without data_last; XOR of i*0x0101 over 0..15 is zero
    got_q.delete();
    pkt_w.delete();
    for (int i = 0; i < DEPTH; i++) pkt_w.push_back(16'(i) * 16'h0101);
    send_pkt(16'hC0DE, 1'b0);
    drain();
    check("t4_count", 48'(got_q.size()), 48'd17);
    check("t4_hdr", got_q[0], 48'hC0DE_0010_0000);
    check("t4_b14", got_q[15], 48'h000E_0E0E_0000);
    check("t4_last", got_q[16], 48'h000F_0F0F_FFFF);

    // Reset in the middle of BODY
    got_q.delete();
    pkt_w = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
    send_pkt(16'h7777, 1'b1);
    repeat (2) tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_valid", {47'h0, flit_valid}, 48'h0);
    check("t5_rst_flit", flitout, 48'h0);
    check("t5_rst_ready", {47'h0, data_ready}, 48'h1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    got_q.delete();
    pkt_w = '{16'h5555};
    send_pkt(16'h00AA, 1'b1);
    drain();
    check("t5_count", 48'(got_q.size()), 48'd2);
`ifdef PACKETIZER_CRC_EN
    check("t5_hdr", got_q[0], 48'h00AA_0001_5555);
`else
    check("t5_hdr", got_q[0], 48'h00AA_0001_0000);
`endif
    check("t5_body", got_q[1], 48'h0000_5555_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packetizer.md
# packetizer

Transmit-side companion of the 48-bit flit de-packetizer. Accepts a stream of 16-bit data words with a valid/ready handshake, buffers one complete packet, then emits it as a header flit followed by one body flit per word on the 48-bit flit link. The last body flit carries the 16'hFFFF end marker that the receiving de-packetizer uses to assert packet_end.

## Interface
- DEPTH, 16: max words per packet and buffer depth; power of two, 2..256.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  16  payload word.
- data_valid  in  1  data_in is valid.
- data_last  in  1  qualifies data_in as the final word of the packet.
- dest  in  16  destination id; sampled with the first word of each packet.
- data_ready  out  1  block can accept a word this cycle.
- flitout  out  48  flit to link.
- flit_valid  out  1  flitout is valid.
- flit_ready  in  1  link accepts flitout this cycle.
- pkt_sent  out  1  one-cycle pulse after the last body flit is accepted.

## Operation
- Word accepted when data_valid && data_ready; flit accepted when flit_valid && flit_ready.
- States:
  - FILL: data_ready=1; accepted words are written at index cnt and cnt increments. The first word (cnt==0) latches dest. Go to HEAD after accepting a word with data_last=1, or the word that makes cnt==DEPTH (forced end; data_last ignored).
  - HEAD: data_ready=0; flitout={dest_q, len[15:0], chk}; len = words buffered (1..DEPTH); chk=16'h0000 (see Configuration). On accept go to BODY with rd=0.
  - BODY: flitout={rd[15:0], word[rd], ctrl}; ctrl=16'hFFFF when rd==len-1, else 16'h0000. On accept rd increments; on accepting the last word go to FILL, clear cnt and rd, pulse pkt_sent.
- len and rd are zero-extended to 16 bits.
- flitout, flit_valid and pkt_sent are registered. data_ready is decoded from state.
- flitout holds stable while flit_valid=1 && flit_ready=0.
- data_valid is ignored outside FILL; data_in has no effect when not accepted.
- Reset, including mid-packet: state FILL, cnt=0, rd=0. Outputs: data_ready=1, flit_valid=0, flitout=48'h0, pkt_sent=0. The partial packet is discarded and no flit is emitted for it.

## Timing
- Last word accepted at edge N: header flit valid after edge N, so it is visible in cycle N+1.
- Each body flit is presented the cycle after the previous flit is accepted. With flit_ready held at 1, one flit per cycle, so len+1 flit cycles per packet.
- pkt_sent is high for the cycle after the last body flit is accepted. data_ready returns to 1 in that same cycle.
- Minimum packet turnaround with flit_ready=1: 1 word cycle + 2 flit cycles; there is no overlap between filling and draining.

## Configuration
- PACKETIZER_CRC_EN defined:
  - A 16-bit XOR accumulator is cleared on entry to FILL and XORs every accepted word.
  - The header chk field carries the accumulator value.
- PACKETIZER_CRC_EN undefined:
  - No accumulator is built.
  - The header chk field is 16'h0000.

## Test plan
- Reset release, idle: data_ready=1, flit_valid=0, flitout=0 and pkt_sent=0 until stimulus.
- Single word 16'hABCD with data_last=1, dest=16'h1234, flit_ready=1:
  - Header 48'h1234_0001_0000, then 48'h0000_ABCD_FFFF, then pkt_sent pulse.
  - With PACKETIZER_CRC_EN the header is 48'h1234_0001_ABCD.
- Three words 16'h3232, 16'h6767, 16'h0001 (last), dest=16'h0002:
  - Header 48'h0002_0003_0000.
  - Body flits 48'h0000_3232_0000, 48'h0001_6767_0000, 48'h0002_0001_FFFF.
  - With CRC the header chk is 16'h5554.
- Backpressure: flit_ready=0 for 5 cycles during BODY; flitout held unchanged, no flit lost or duplicated, data_ready stays 0.
- Overflow: DEPTH=16 words with data_last never asserted; forced end at word 16, header len=16'h0010, last body flit rd=16'h000F with ctrl=FFFF.
- Reset asserted mid-BODY: outputs return to reset values immediately; the next packet starts with a fresh header and rd=0.
